// File: rtl/compalu_issue_ctrl.sv
// Issue sequencer for CompALU: queues R-type instructions, issues one every two cycles and
// writes results back to rd. Define COMPALU_CTRL_STATS_EN to add retired/illegal counters.
module compalu_issue_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_in,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [31:0]      alu_instr,
    input  logic [31:0]      alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             done_valid,
    output logic             done_zero,
    output logic             done_carry,
    output logic             done_illegal,
    output logic             busy,
`ifdef COMPALU_CTRL_STATS_EN
    output logic [15:0]      retired_cnt,
    output logic [15:0]      illegal_cnt,
`endif
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL    = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e           state;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_nxt;
    logic [31:0]      head;
    logic             push;
    logic             pop;
    logic             legal;

    assign head        = mem[rd_ptr];
    assign instr_ready = count < FULL;
    assign push        = instr_valid && instr_ready;
    assign pop         = state == StWb;
    assign alu_instr   = (state == StIdle) ? 32'h0 : head;
    assign busy        = state != StIdle;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_comb begin
        legal = 1'b0;
        if (head[31:26] == 6'b0) begin
            case (head[5:0])
                6'b100100, 6'b100011, 6'b100101, 6'b000010, 6'b000000: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            done_valid   <= 1'b0;
            done_zero    <= 1'b0;
            done_carry   <= 1'b0;
            done_illegal <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            count        <= count_nxt;
            rf_we        <= 1'b0;
            done_valid   <= 1'b0;
            done_zero    <= 1'b0;
            done_carry   <= 1'b0;
            done_illegal <= 1'b0;
            case (state)
                StIdle: begin
                    if (count != '0) begin
                        state <= StExec;
                    end
                end
                StExec: begin
                    // CompALU is combinational, so its outputs are final at this edge.
                    rf_we        <= legal && (head[15:11] != 5'd0);
                    rf_waddr     <= head[15:11];
                    rf_wdata     <= alu_out;
                    done_valid   <= 1'b1;
                    done_zero    <= legal && alu_zero;
                    done_carry   <= legal && alu_carry;
                    done_illegal <= !legal;
                    state        <= StWb;
                end
                StWb: begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    state  <= (count_nxt != '0) ? StExec : StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef COMPALU_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            illegal_cnt <= '0;
        end else if (done_valid) begin
            if (retired_cnt != 16'hFFFF) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if (done_illegal && illegal_cnt != 16'hFFFF) begin
                illegal_cnt <= illegal_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_compalu_issue_ctrl.sv
// Bench for compalu_issue_ctrl: pairs it with a small CompALU stand-in and checks every
// retirement against an in-order architectural model of the instruction stream.
module tb_compalu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SLL  = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_instr;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_carry;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done_valid;
    logic        done_zero;
    logic        done_carry;
    logic        done_illegal;
    logic        busy;
    logic [2:0]  count;
`ifdef COMPALU_CTRL_STATS_EN
    logic [15:0] retired_cnt;
    logic [15:0] illegal_cnt;
`endif

    always #5 clk = ~clk;

    compalu_issue_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .alu_instr    (alu_instr),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .done_valid   (done_valid),
        .done_zero    (done_zero),
        .done_carry   (done_carry),
        .done_illegal (done_illegal),
        .busy         (busy),
`ifdef COMPALU_CTRL_STATS_EN
        .retired_cnt  (retired_cnt),
        .illegal_cnt  (illegal_cnt),
`endif
        .count        (count)
    );

    // CompALU stand-in: register file plus combinational datapath; carry means "no borrow".
    logic        load;
    logic [31:0] rf [32];
    logic [31:0] a_op;
    logic [31:0] b_op;

    always_comb begin
        a_op      = rf[alu_instr[25:21]];
        b_op      = rf[alu_instr[20:16]];
        alu_carry = 1'b0;
        case (alu_instr[5:0])
            F_AND:   alu_out = a_op & b_op;
            F_OR:    alu_out = a_op | b_op;
            F_SUBU: begin
                alu_out   = a_op - b_op;
                alu_carry = a_op >= b_op;
            end
            F_SRL:   alu_out = b_op >> alu_instr[10:6];
            F_SLL:   alu_out = b_op << alu_instr[10:6];
            default: alu_out = 32'h0;
        endcase
        alu_zero = alu_out == 32'h0;
    end

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
            rf[13] <= 32'h12345678;
            rf[30] <= 32'h7F7F7F7F;
            rf[31] <= 32'hFFFFFFFF;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Reference model: architectural registers updated in program order at accept time.
    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        zero;
        logic        carry;
        logic        illegal;
    } exp_t;

    logic [31:0] mreg [32];
    exp_t        expq [$];
    int          mcnt;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        retired;
    logic        accepted;
    logic        last_we;
    logic [4:0]  last_waddr;
    logic [31:0] last_wdata;
    logic        last_zero;
    logic        last_illegal;
    int          last_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    task automatic model_accept(input logic [31:0] ins);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ok;
        a  = mreg[ins[25:21]];
        b  = mreg[ins[20:16]];
        ok = ins[31:26] == 6'b0;
        r  = 32'h0;
        e.carry = 1'b0;
        case (ins[5:0])
            F_AND:   r = a & b;
            F_OR:    r = a | b;
            F_SUBU: begin
                r = a - b;
                e.carry = a >= b;
            end
            F_SRL:   r = b >> ins[10:6];
            F_SLL:   r = b << ins[10:6];
            default: ok = 1'b0;
        endcase
        e.illegal = !ok;
        e.zero    = ok && r == 32'h0;
        e.carry   = ok && e.carry;
        e.we      = ok && ins[15:11] != 5'd0;
        e.waddr   = ins[15:11];
        e.wdata   = r;
        if (e.we) mreg[ins[15:11]] = r;
        expq.push_back(e);
    endtask

    // One cycle: sample at the falling edge, score any retirement, then drive the next push.
    task automatic step(input logic v, input logic [31:0] ins);
        int   pre;
        exp_t e;
        @(negedge clk);
        cyc++;
        pre      = mcnt;
        retired  = done_valid;
        chk("count", 32'(count), 32'(mcnt));
        chk("instr_ready", instr_ready, pre < DEPTH);
        if (done_valid) begin
            last_we      = rf_we;
            last_waddr   = rf_waddr;
            last_wdata   = rf_wdata;
            last_zero    = done_zero;
            last_illegal = done_illegal;
            last_cyc     = cyc;
            if (expq.size() == 0) begin
                chk("spurious_retire", done_valid, 1'b0);
            end else begin
                e = expq.pop_front();
                mcnt--;
                chk("rf_we", rf_we, e.we);
                if (e.we) begin
                    chk("rf_waddr", rf_waddr, e.waddr);
                    chk("rf_wdata", rf_wdata, e.wdata);
                end
                chk("done_zero", done_zero, e.zero);
                chk("done_carry", done_carry, e.carry);
                chk("done_illegal", done_illegal, e.illegal);
            end
        end else begin
            chk("rf_we_quiet", rf_we, 1'b0);
            chk("illegal_quiet", done_illegal, 1'b0);
        end
        accepted = v && pre < DEPTH;
        if (accepted) begin
            model_accept(ins);
            mcnt++;
        end
        instr_valid = v;
        instr_in    = ins;
    endtask

    task automatic wait_retire(output int n);
        n = 0;
        retired = 1'b0;
        while (!retired && n < 20) begin
            step(1'b0, 32'h0);
            n++;
        end
        chk("retire_timeout", retired, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 60) begin
            step(1'b0, 32'h0);
            n++;
        end
        chk("drain_queue", 32'(expq.size()), 0);
        chk("drain_count", 32'(count), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  pool [8] = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd9, 5'd13, 5'd30, 5'd31};
        logic [5:0]  fn;
        logic [5:0]  op;
        case ($urandom_range(0, 5))
            0:       fn = F_AND;
            1:       fn = F_SUBU;
            2:       fn = F_OR;
            3:       fn = F_SRL;
            4:       fn = F_SLL;
            default: fn = 6'b100000;
        endcase
        op = ($urandom_range(0, 9) == 0) ? 6'b000100 : 6'b0;
        return {op, pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                pool[$urandom_range(0, 7)], 5'($urandom_range(0, 31)), fn};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          refused;
        int          nret;
        logic [15:0] r0;
        logic [15:0] i0;
        rst         = 1'b1;
        load        = 1'b1;
        instr_valid = 1'b0;
        instr_in    = 32'h0;
        mcnt        = 0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mreg[13] = 32'h12345678;
        mreg[30] = 32'h7F7F7F7F;
        mreg[31] = 32'hFFFFFFFF;
        r0 = '0;
        i0 = '0;
        repeat (2) @(negedge clk);

        chk("rst_count", 32'(count), 0);
        chk("rst_alu_instr", alu_instr, 32'h0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", 32'(rf_waddr), 0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", instr_ready, 1'b1);
        rst  = 1'b0;
        load = 1'b0;

        // SUBU R1 = R31 - R30
        step(1'b1, rtype(31, 30, 1, 0, F_SUBU));
        wait_retire(n);
        chk("t1_latency", n, 3);
        chk("t1_we", last_we, 1'b1);
        chk("t1_waddr", 32'(last_waddr), 1);
        chk("t1_wdata", last_wdata, 32'h80808080);
        chk("t1_zero", last_zero, 1'b0);
        step(1'b0, 32'h0);
        chk("t1_r1", rf[1], 32'h80808080);

        // Back-to-back SUBU (zero result) then OR
        step(1'b1, rtype(31, 31, 3, 0, F_SUBU));
        step(1'b1, rtype(0, 13, 4, 0, F_OR));
        wait_retire(n);
        chk("t2_wdata0", last_wdata, 32'h0);
        chk("t2_zero", last_zero, 1'b1);
        chk("t2_waddr0", 32'(last_waddr), 3);
        n = last_cyc;
        step(1'b0, 32'h0);
        chk("t2_busy_mid", busy, 1'b1);
        step(1'b0, 32'h0);
        chk("t2_second_retire", retired, 1'b1);
        chk("t2_gap", last_cyc - n, 2);
        chk("t2_wdata1", last_wdata, 32'h12345678);

        // Dependent pair: AND reads R5 written by the preceding SRL
        step(1'b1, rtype(0, 31, 5, 1, F_SRL));
        step(1'b1, rtype(5, 30, 6, 0, F_AND));
        wait_retire(n);
        wait_retire(n);
        step(1'b0, 32'h0);
        chk("t3_r5", rf[5], 32'h7FFFFFFF);
        chk("t3_r6", rf[6], 32'h7F7F7F7F);
        drain();

        // Push faster than the drain rate until the FIFO fills
        refused = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rtype(31, 13, 7 + (i % 3), 0, F_SUBU));
            if (!accepted) refused++;
        end
        chk("t4_refused_any", refused > 0, 1'b1);
        drain();

        // Illegal opcode, then SLL to R0
`ifdef COMPALU_CTRL_STATS_EN
        r0 = retired_cnt;
        i0 = illegal_cnt;
`endif
        step(1'b1, {6'b000100, 5'd31, 5'd30, 5'd2, 5'd0, F_SUBU});
        step(1'b1, rtype(0, 31, 0, 0, F_SLL));
        wait_retire(n);
        chk("t5_illegal", last_illegal, 1'b1);
        chk("t5_ill_we", last_we, 1'b0);
        wait_retire(n);
        chk("t5_r0_we", last_we, 1'b0);
        chk("t5_r0_legal", last_illegal, 1'b0);
        step(1'b0, 32'h0);
        chk("t5_r0", rf[0], 32'h0);
`ifdef COMPALU_CTRL_STATS_EN
        chk("t5_retired_cnt", 32'(16'(retired_cnt - r0)), 2);
        chk("t5_illegal_cnt", 32'(16'(illegal_cnt - i0)), 1);
`endif
        drain();

        // Reset during WB with entries still queued
        retired = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, rtype(13, 30, 9, 0, F_OR));
        if (!retired) wait_retire(n);
        rst         = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("t6_count", 32'(count), 0);
        chk("t6_rf_we", rf_we, 1'b0);
        chk("t6_alu_instr", alu_instr, 32'h0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done_valid, 1'b0);
        rst = 1'b0;
        expq.delete();
        mcnt = 0;
        for (int i = 0; i < 32; i++) mreg[i] = rf[i];
        nret = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0);
            if (retired) nret++;
        end
        chk("t6_no_retire", nret, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 1)), rand_instr());
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
